// File: rtl/sdram_arbiter.sv
// Two-port front end for the SDRAM controller user port: fixed priority for
// port 0 with a bounded port-1 starvation window, one outstanding transaction.
module sdram_arbiter #(
  parameter int unsigned ADDR_W      = 23,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_STREAK  = 4,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              ctrl_rw,
  output logic [DATA_W-1:0] ctrl_wdata,
  output logic              ctrl_in_valid,
  input  logic              ctrl_busy,
  input  logic [DATA_W-1:0] ctrl_rdata,
  input  logic              ctrl_out_valid,
  input  logic              err_clr,
  output logic              err_timeout,
  output logic              grant_id
);

  localparam int unsigned STREAK_W = 3;
  localparam int unsigned TMO_W    = 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACK = 3'd2,
    WAIT_RD  = 3'd3,
    WAIT_WR  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [STREAK_W-1:0] streak, streak_nxt;
  logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_nxt;

  logic              arb, win, in_wait, tmo_hit, tmo_abort, rd_done, wr_done;
  logic [DATA_W-1:0] rd_value;

  logic [ADDR_W-1:0] ctrl_addr_nxt;
  logic              ctrl_rw_nxt, ctrl_in_valid_nxt;
  logic [DATA_W-1:0] ctrl_wdata_nxt;
  logic              req0_ready_nxt, req1_ready_nxt;
  logic              req0_rvalid_nxt, req1_rvalid_nxt;
  logic [DATA_W-1:0] req0_rdata_nxt, req1_rdata_nxt;
  logic              err_timeout_nxt, grant_id_nxt;

  // Arbitration and completion conditions shared by both combinational blocks
  always_comb begin
    arb       = (state == IDLE) && !ctrl_busy && (req0_valid || req1_valid);
    win       = req1_valid && (!req0_valid || (streak == STREAK_W'(MAX_STREAK)));
    in_wait   = (state == WAIT_ACK) || (state == WAIT_RD) || (state == WAIT_WR);
    rd_done   = ((state == WAIT_ACK) && ctrl_out_valid && !ctrl_rw) ||
                ((state == WAIT_RD) && ctrl_out_valid);
    wr_done   = (state == WAIT_WR) && !ctrl_busy;
    tmo_hit   = in_wait && (tmo_cnt == TMO_W'(TIMEOUT_CYC));
    // A genuine completion in the timeout cycle is honoured rather than aborted
    tmo_abort = tmo_hit && !rd_done && !wr_done;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (arb) state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (rd_done || tmo_abort) state_nxt = IDLE;
        else if (ctrl_busy)       state_nxt = ctrl_rw ? WAIT_WR : WAIT_RD;
      end
      WAIT_RD:  if (rd_done || tmo_abort) state_nxt = IDLE;
      WAIT_WR:  if (wr_done || tmo_abort) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Next values of every registered output and of the internal counters
  always_comb begin
    ctrl_addr_nxt     = ctrl_addr;
    ctrl_rw_nxt       = ctrl_rw;
    ctrl_wdata_nxt    = ctrl_wdata;
    ctrl_in_valid_nxt = 1'b0;
    req0_ready_nxt    = 1'b0;
    req1_ready_nxt    = 1'b0;
    req0_rvalid_nxt   = 1'b0;
    req1_rvalid_nxt   = 1'b0;
    req0_rdata_nxt    = req0_rdata;
    req1_rdata_nxt    = req1_rdata;
    grant_id_nxt      = grant_id;
    err_timeout_nxt   = err_timeout & ~err_clr;
    streak_nxt        = streak;
    tmo_cnt_nxt       = tmo_cnt;
    rd_value          = rd_done ? ctrl_rdata : '0;

    if (arb) begin
      grant_id_nxt      = win;
      ctrl_rw_nxt       = win ? req1_rw    : req0_rw;
      ctrl_addr_nxt     = win ? req1_addr  : req0_addr;
      ctrl_wdata_nxt    = win ? req1_wdata : req0_wdata;
      ctrl_in_valid_nxt = 1'b1;
      req0_ready_nxt    = !win;
      req1_ready_nxt    = win;
      tmo_cnt_nxt       = '0;
      if (win || !req1_valid)    streak_nxt = '0;
      else if (streak != '1)     streak_nxt = streak + STREAK_W'(1);
    end

    if (in_wait) tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
    if (tmo_abort) err_timeout_nxt = 1'b1;

    // An aborted read still answers its requester, with zero data
    if (rd_done || (tmo_abort && !ctrl_rw)) begin
      if (grant_id) begin
        req1_rvalid_nxt = 1'b1;
        req1_rdata_nxt  = rd_value;
      end else begin
        req0_rvalid_nxt = 1'b1;
        req0_rdata_nxt  = rd_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_addr     <= '0;
      ctrl_rw       <= 1'b0;
      ctrl_wdata    <= '0;
      ctrl_in_valid <= 1'b0;
      req0_ready    <= 1'b0;
      req1_ready    <= 1'b0;
      req0_rvalid   <= 1'b0;
      req1_rvalid   <= 1'b0;
      req0_rdata    <= '0;
      req1_rdata    <= '0;
      grant_id      <= 1'b0;
      err_timeout   <= 1'b0;
      streak        <= '0;
      tmo_cnt       <= '0;
    end else begin
      ctrl_addr     <= ctrl_addr_nxt;
      ctrl_rw       <= ctrl_rw_nxt;
      ctrl_wdata    <= ctrl_wdata_nxt;
      ctrl_in_valid <= ctrl_in_valid_nxt;
      req0_ready    <= req0_ready_nxt;
      req1_ready    <= req1_ready_nxt;
      req0_rvalid   <= req0_rvalid_nxt;
      req1_rvalid   <= req1_rvalid_nxt;
      req0_rdata    <= req0_rdata_nxt;
      req1_rdata    <= req1_rdata_nxt;
      grant_id      <= grant_id_nxt;
      err_timeout   <= err_timeout_nxt;
      streak        <= streak_nxt;
      tmo_cnt       <= tmo_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small behavioural SDRAM controller
// model; a vector table plus hand-written multi-cycle sequences.
module tb_sdram_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_rw, req0_ready, req0_rvalid;
  logic [22:0] req0_addr;
  logic [31:0] req0_wdata, req0_rdata;
  logic        req1_valid, req1_rw, req1_ready, req1_rvalid;
  logic [22:0] req1_addr;
  logic [31:0] req1_wdata, req1_rdata;
  logic [22:0] ctrl_addr;
  logic        ctrl_rw, ctrl_in_valid, ctrl_busy, ctrl_out_valid;
  logic [31:0] ctrl_wdata, ctrl_rdata;
  logic        err_clr, err_timeout, grant_id;

  sdram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata),
    .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw), .ctrl_wdata(ctrl_wdata),
    .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy), .ctrl_rdata(ctrl_rdata),
    .ctrl_out_valid(ctrl_out_valid),
    .err_clr(err_clr), .err_timeout(err_timeout), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Controller model knobs and state
  int          m_lat   = 3;
  logic        m_hit   = 1'b0;
  logic        m_dead  = 1'b0;
  logic [31:0] m_data  = 32'h0;
  int          m_phase = 0;
  int          m_cnt   = 0;
  logic        m_rw    = 1'b0;
  int          m_issues = 0;
  int          rv0_cnt = 0;
  int          rv1_cnt = 0;

  // Busy rises one cycle after in_valid; hit mode returns data with busy's rise
  always @(negedge clk) begin
    ctrl_out_valid = 1'b0;
    ctrl_rdata     = 32'hDEADBEEF;
    if (rst) begin
      ctrl_busy = 1'b0;
      m_phase   = 0;
    end else begin
      case (m_phase)
        0: if (ctrl_in_valid) begin
          m_issues++;
          m_rw    = ctrl_rw;
          m_phase = 1;
        end
        1: begin
          ctrl_busy = 1'b1;
          m_cnt     = 0;
          if (!m_rw && m_hit && !m_dead) begin
            ctrl_out_valid = 1'b1;
            ctrl_rdata     = m_data;
            m_phase        = 3;
          end else m_phase = 2;
        end
        2: begin
          m_cnt++;
          if (!m_dead && m_cnt >= m_lat) begin
            if (!m_rw) begin
              ctrl_out_valid = 1'b1;
              ctrl_rdata     = m_data;
            end
            m_phase = 3;
          end
        end
        default: begin
          ctrl_busy = 1'b0;
          m_phase   = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (req0_rvalid) rv0_cnt++;
    if (req1_rvalid) rv1_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{req0_ready, req0_rvalid, req0_rdata, req1_ready, req1_rvalid, req1_rdata,
             ctrl_addr, ctrl_rw, ctrl_wdata, ctrl_in_valid, err_timeout, grant_id};
  endfunction

  // Present one request, wait for its ready pulse and check the issued fields
  task automatic send(input logic port, input logic rw, input logic [22:0] addr,
                      input logic [31:0] wdata);
    int cyc = 0;
    logic rdy = 1'b0;
    if (port) begin
      req1_rw = rw; req1_addr = addr; req1_wdata = wdata; req1_valid = 1'b1;
    end else begin
      req0_rw = rw; req0_addr = addr; req0_wdata = wdata; req0_valid = 1'b1;
    end
    while (!rdy && cyc < 100) begin
      tick(1);
      cyc++;
      rdy = port ? req1_ready : req0_ready;
    end
    check("ready_seen", 64'(rdy), 64'(1));
    check("in_valid_with_ready", 64'(ctrl_in_valid), 64'(1));
    check("ctrl_rw", 64'(ctrl_rw), 64'(rw));
    check("ctrl_addr", 64'(ctrl_addr), 64'(addr));
    check("ctrl_wdata", 64'(ctrl_wdata), 64'(wdata));
    check("grant_id", 64'(grant_id), 64'(port));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  typedef struct {
    logic        port;
    logic        rw;
    logic [22:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        hit;
    logic [31:0] mdata;
    int          exp_rv0;
    int          exp_rv1;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];
  int   exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    int b0, b1, cyc, n_iss;
    int seq[$];

    vecs[0] = '{1'b0, 1'b1, 23'h000010, 32'hA5A5A5A5, 3, 1'b0, 32'h0,        0, 0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 23'h000400, 32'h0,        6, 1'b0, 32'h12345678, 0, 1, 32'h12345678};
    vecs[2] = '{1'b0, 1'b0, 23'h000020, 32'h0,        1, 1'b1, 32'hCAFEF00D, 1, 0, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 1'b1, 23'h7FFFFF, 32'hFFFFFFFF, 2, 1'b0, 32'h0,        0, 0, 32'h12345678};
    vecs[4] = '{1'b0, 1'b0, 23'h123456, 32'h0,        1, 1'b0, 32'h0BADC0DE, 1, 0, 32'h0BADC0DE};

    rst = 1'b1; err_clr = 1'b0;
    req0_valid = 1'b0; req0_rw = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_rw = 1'b0; req1_addr = '0; req1_wdata = '0;
    ctrl_busy = 1'b0; ctrl_out_valid = 1'b0; ctrl_rdata = '0;

    tick(3);
    check("reset_outputs", 64'(any_out()), 64'(0));
    rst = 1'b0;
    tick(10);
    check("idle_outputs", 64'(any_out()), 64'(0));
    check("idle_no_issue", 64'(m_issues), 64'(0));

    foreach (vecs[i]) begin
      m_lat = vecs[i].lat; m_hit = vecs[i].hit; m_data = vecs[i].mdata;
      b0 = rv0_cnt; b1 = rv1_cnt;
      send(vecs[i].port, vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      tick(20);
      check($sformatf("v%0d_rv0", i), 64'(rv0_cnt - b0), 64'(vecs[i].exp_rv0));
      check($sformatf("v%0d_rv1", i), 64'(rv1_cnt - b1), 64'(vecs[i].exp_rv1));
      check($sformatf("v%0d_rdata", i),
            64'(vecs[i].port ? req1_rdata : req0_rdata), 64'(vecs[i].exp_rdata));
    end
    check("issues_after_table", 64'(m_issues), 64'(5));
    check("no_err_after_table", 64'(err_timeout), 64'(0));

    // Both ports continuously requesting reads: starvation bound
    m_lat = 2; m_hit = 1'b0;
    req0_rw = 1'b0; req1_rw = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    n_iss = 0; cyc = 0;
    while (n_iss < 10 && cyc < 500) begin
      tick(1);
      cyc++;
      if (ctrl_in_valid) begin
        seq.push_back(int'(grant_id));
        n_iss++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("streak_issue_count", 64'(n_iss), 64'(10));
    for (int i = 0; i < 10; i++)
      check($sformatf("streak_grant%0d", i),
            64'(i < seq.size() ? seq[i] : -1), 64'(exp_seq[i]));
    tick(20);

    // Controller never answers a port-0 read
    m_dead = 1'b1;
    b0 = rv0_cnt;
    send(1'b0, 1'b0, 23'h000100, 32'h0);
    cyc = 0;
    while (!req0_rvalid && cyc < 1200) begin
      tick(1);
      cyc++;
    end
    check("tmo_latency", 64'(cyc), 64'(1025));
    check("tmo_rdata_zero", 64'(req0_rdata), 64'(0));
    check("tmo_err_set", 64'(err_timeout), 64'(1));
    m_dead = 1'b0;
    tick(5);
    check("tmo_err_sticky", 64'(err_timeout), 64'(1));
    check("tmo_one_rvalid", 64'(rv0_cnt - b0), 64'(1));
    m_lat = 2; m_data = 32'h55AA55AA;
    b0 = rv0_cnt;
    send(1'b0, 1'b0, 23'h000200, 32'h0);
    tick(15);
    check("post_tmo_rv0", 64'(rv0_cnt - b0), 64'(1));
    check("post_tmo_rdata", 64'(req0_rdata), 64'(32'h55AA55AA));
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("err_clr", 64'(err_timeout), 64'(0));

    // Reset while a read is in WAIT_RD
    m_lat = 8; m_data = 32'h77777777;
    send(1'b0, 1'b0, 23'h000300, 32'h0);
    tick(4);
    b0 = rv0_cnt; b1 = rv1_cnt;
    rst = 1'b1;
    tick(1);
    check("midtxn_reset_outputs", 64'(any_out()), 64'(0));
    tick(1);
    rst = 1'b0;
    tick(15);
    check("midtxn_no_rvalid", 64'(rv0_cnt - b0 + rv1_cnt - b1), 64'(0));
    m_lat = 2; m_data = 32'h3C3C3C3C;
    b0 = rv0_cnt;
    send(1'b0, 1'b0, 23'h000304, 32'h0);
    tick(15);
    check("post_reset_rv0", 64'(rv0_cnt - b0), 64'(1));
    check("post_reset_rdata", 64'(req0_rdata), 64'(32'h3C3C3C3C));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
